// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED matrix row scanner.
//   - 2-bit pixel codes stored in the frame buffer
//   - scan FSM state encoding (also exported on the debug state port)
//   - helpers that split a pixel code into its red / green column bits
package led_pkg;

  localparam logic [1:0] PIX_OFF  = 2'd0;
  localparam logic [1:0] PIX_RED  = 2'd1;
  localparam logic [1:0] PIX_GRN  = 2'd2;
  localparam logic [1:0] PIX_BOTH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_BLANK = 2'd2,
    ST_SHOW  = 2'd3
  } scan_state_t;

  function automatic logic pix_red(input logic [1:0] code);
    return (code == PIX_RED) || (code == PIX_BOTH);
  endfunction

  function automatic logic pix_grn(input logic [1:0] code);
    return (code == PIX_GRN) || (code == PIX_BOTH);
  endfunction

endpackage

// File: rtl/led_row_fetch.sv
// led_row_fetch: reads one matrix row from the frame-buffer RAM into the
// red/green column shadow registers.
//   clk, nrst    clock, synchronous active-high reset
//   i_start      pulse: begin fetching the row whose first pixel is i_base
//   i_base       frame-buffer address of column 0 of the row
//   i_data       pixel code returned by the RAM
//   o_address    RAM read address
//   o_rd_en      RAM read strobe
//   o_r_sh/o_g_sh  column shadow registers (cleared at every i_start)
//   o_done       high in the last fetch cycle (final capture happens at its end)
// RAM handshake: o_rd_en qualifies o_address; i_data is valid exactly one
// cycle after each o_rd_en cycle; there is no back-pressure.
module led_row_fetch
  import led_pkg::*;
#(
  parameter int COLS = 8,
  parameter int AW   = 6
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            i_start,
  input  logic [AW-1:0]   i_base,
  input  logic [1:0]      i_data,
  output logic [AW-1:0]   o_address,
  output logic            o_rd_en,
  output logic [COLS-1:0] o_r_sh,
  output logic [COLS-1:0] o_g_sh,
  output logic            o_done
);

  localparam int FW = $clog2(COLS + 1);
  localparam logic [FW-1:0] LAST    = FW'(COLS);
  localparam logic [FW-1:0] LAST_RD = FW'(COLS - 1);

  logic [FW-1:0]   r_cnt;
  logic            r_active;
  logic [AW-1:0]   r_addr;
  logic            r_rd_en;
  logic [COLS-1:0] r_r_sh;
  logic [COLS-1:0] r_g_sh;

  // r_cnt is the fetch cycle index 0..COLS; the data captured in cycle
  // r_cnt belongs to the read issued in cycle r_cnt-1.
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_rd_en  <= 1'b0;
      r_r_sh   <= '0;
      r_g_sh   <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_addr   <= i_base;
      r_rd_en  <= 1'b1;
      r_r_sh   <= '0;
      r_g_sh   <= '0;
    end else if (r_active) begin
      for (int c = 0; c < COLS; c++) begin
        if (r_cnt == FW'(c + 1)) begin
          r_r_sh[c] <= pix_red(i_data);
          r_g_sh[c] <= pix_grn(i_data);
        end
      end
      if (r_cnt == LAST) begin
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_cnt < LAST_RD) begin
        r_rd_en <= 1'b1;
        r_addr  <= r_addr + 1'b1;
      end else begin
        r_rd_en <= 1'b0;
      end
    end
  end

  assign o_address = r_addr;
  assign o_rd_en   = r_rd_en;
  assign o_r_sh    = r_r_sh;
  assign o_g_sh    = r_g_sh;
  assign o_done    = r_active && (r_cnt == LAST);

endmodule

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: row-scanning driver for a bicolour LED dot matrix.
// Each row slot is FETCH (COLS+1) -> BLANK (BLANK) -> SHOW (DWELL cycles).
//   clk, nrst        clock, synchronous active-high reset
//   enable           scanning permitted (sampled in IDLE and last SHOW cycle)
//   bright           brightness 0..3, latched on entry to SHOW
//   data             pixel code from RAM, one cycle after rd_en
//   address, rd_en   frame-buffer read port
//   row              active-low one-hot row drive (all ones = off)
//   r_col, g_col     active-high column drives
//   frame_done       one-cycle pulse in the first cycle after the last row
//   busy             high in any state except IDLE
//   dbg_state        current scan FSM state
module led_matrix_scan
  import led_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DWELL = 1024,
  parameter int BLANK = 16,
  parameter int AW    = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            enable,
  input  logic [1:0]      bright,
  input  logic [1:0]      data,
  output logic [AW-1:0]   address,
  output logic            rd_en,
  output logic [ROWS-1:0] row,
  output logic [COLS-1:0] r_col,
  output logic [COLS-1:0] g_col,
  output logic            frame_done,
  output logic            busy,
  output scan_state_t     dbg_state
);

  // The shared BLANK/SHOW counter must also hold BLANK-1 when BLANK > DWELL.
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(ROWS);
  localparam int OW      = CW + 2;

  scan_state_t     r_state;
  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   r_cur_row;
  logic [1:0]      r_b_lat;
  logic [ROWS-1:0] r_row;
  logic [COLS-1:0] r_rcol;
  logic [COLS-1:0] r_gcol;
  logic            r_frame_done;
  logic            r_busy;

  logic            w_last_show;
  logic [RW-1:0]   w_next_row;
  logic            w_start;
  logic [RW-1:0]   w_start_row;
  logic [AW-1:0]   w_base;
  logic [OW-1:0]   w_on_x4;
  logic [OW-1:0]   w_on;
  logic            w_col_on;
  logic [ROWS-1:0] w_row_drive;
  logic            w_fetch_done;
  logic [COLS-1:0] w_r_sh;
  logic [COLS-1:0] w_g_sh;

  assign w_last_show = (r_state == ST_SHOW) && (r_cnt == CW'(DWELL - 1));
  assign w_next_row  = (r_cur_row == RW'(ROWS - 1)) ? '0 : r_cur_row + 1'b1;

  // The fetch is started on the same edge the FSM enters FETCH, so the row
  // it reads is the post-increment row when leaving SHOW.
  assign w_start     = enable && ((r_state == ST_IDLE) || w_last_show);
  assign w_start_row = (r_state == ST_SHOW) ? w_next_row : r_cur_row;
  assign w_base      = AW'(w_start_row) * AW'(COLS);

  // Columns stay lit while the next SHOW cycle index is below on_cycles.
  assign w_on_x4  = (OW'(r_b_lat) + OW'(1)) * OW'(DWELL);
  assign w_on     = w_on_x4 >> 2;
  assign w_col_on = (OW'(r_cnt) + OW'(1)) < w_on;

  assign w_row_drive = ~({{(ROWS-1){1'b0}}, 1'b1} << r_cur_row);

  led_row_fetch #(
    .COLS (COLS),
    .AW   (AW)
  ) u_fetch (
    .clk       (clk),
    .nrst      (nrst),
    .i_start   (w_start),
    .i_base    (w_base),
    .i_data    (data),
    .o_address (address),
    .o_rd_en   (rd_en),
    .o_r_sh    (w_r_sh),
    .o_g_sh    (w_g_sh),
    .o_done    (w_fetch_done)
  );

  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_cur_row    <= '0;
      r_b_lat      <= '0;
      r_row        <= '1;
      r_rcol       <= '0;
      r_gcol       <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_FETCH;
            r_busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (w_fetch_done) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
          end
        end
        ST_BLANK: begin
          if (r_cnt == CW'(BLANK - 1)) begin
            // on_cycles is at least DWELL/4 >= 1, so SHOW cycle 0 is always lit.
            r_state <= ST_SHOW;
            r_cnt   <= '0;
            r_b_lat <= bright;
            r_row   <= w_row_drive;
            r_rcol  <= w_r_sh;
            r_gcol  <= w_g_sh;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (w_last_show) begin
            r_row     <= '1;
            r_rcol    <= '0;
            r_gcol    <= '0;
            r_cur_row <= w_next_row;
            if (r_cur_row == RW'(ROWS - 1)) begin
              r_frame_done <= 1'b1;
            end
            r_state <= enable ? ST_FETCH : ST_IDLE;
            r_busy  <= enable;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_col_on) begin
              r_rcol <= '0;
              r_gcol <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign row        = r_row;
  assign r_col      = r_rcol;
  assign g_col      = r_gcol;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule
